// File: rtl/seq_comp_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM states and
// verdict encodings, plus the verdict-to-one-hot result mapping.
package seq_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] V_EQ = 2'd0;
  localparam logic [1:0] V_GT = 2'd1;
  localparam logic [1:0] V_LT = 2'd2;

  // Result bus ordering is {eq, gt, lt}.
  function automatic logic [2:0] verd_onehot(input logic [1:0] v);
    logic [2:0] r;
    r = 3'b000;
    case (v)
      V_EQ:    r = 3'b100;
      V_GT:    r = 3'b010;
      V_LT:    r = 3'b001;
      default: r = 3'b100;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational unsigned comparator for one DIGIT-bit slice.
module comp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator, DIGIT bits per cycle, MSB digit first.
// Optional build macro SEQ_COMP_EARLY_EXIT_EN ends the compare at the first differing digit.
module seq_mag_comp
  import seq_comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [1:0]       verd_q, verd_d;
  logic             done_q, done_d;
  logic [2:0]       res_q, res_d;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_eq, dig_gt, dig_lt;
  logic [1:0]       dig_verd;
  logic             last_dig;
  logic [WIDTH-1:0] sign_flip;

  // Offset-binary trick: flipping both MSBs turns a signed compare into unsigned.
  assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  assign dig_a = a_q[int'(idx_q)*DIGIT +: DIGIT];
  assign dig_b = b_q[int'(idx_q)*DIGIT +: DIGIT];

  comp_digit #(.DIGIT(DIGIT)) u_dig (
    .a_i  (dig_a),
    .b_i  (dig_b),
    .eq_o (dig_eq),
    .gt_o (dig_gt),
    .lt_o (dig_lt)
  );

  assign dig_verd = dig_gt ? V_GT : (dig_lt ? V_LT : V_EQ);
  assign last_dig = (idx_q == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    verd_d  = verd_q;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        // done_q high means we are in the pulse cycle; starts are dropped there.
        if (start && !done_q) begin
          a_d     = a ^ sign_flip;
          b_d     = b ^ sign_flip;
          idx_d   = CW'(NDIG - 1);
          verd_d  = V_EQ;
          state_d = CMP;
        end
      end
      CMP: begin
        if (verd_q == V_EQ) verd_d = dig_verd;
        idx_d = idx_q - CW'(1);
`ifdef SEQ_COMP_EARLY_EXIT_EN
        if (last_dig || !dig_eq) state_d = DONE;
`else
        if (last_dig) state_d = DONE;
`endif
      end
      DONE: begin
        done_d  = 1'b1;
        res_d   = verd_onehot(verd_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      verd_q  <= V_EQ;
      done_q  <= 1'b0;
      res_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      verd_q  <= verd_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign {eq, gt, lt} = res_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Scoreboard bench for seq_mag_comp (WIDTH=16, DIGIT=4); honours SEQ_COMP_EARLY_EXIT_EN.
module tb_seq_mag_comp;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, eq, gt, lt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];
  logic [2:0] last_res = 3'b000;
  logic       prev_done = 1'b0;

  seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic sm);
    if (sm) begin
      if ($signed(ta) == $signed(tb_)) return 3'b100;
      return ($signed(ta) > $signed(tb_)) ? 3'b010 : 3'b001;
    end
    if (ta == tb_) return 3'b100;
    return (ta > tb_) ? 3'b010 : 3'b001;
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_);
`ifdef SEQ_COMP_EARLY_EXIT_EN
    for (int j = 1; j <= NDIG; j++)
      if (ta[(NDIG-j)*DIGIT +: DIGIT] != tb_[(NDIG-j)*DIGIT +: DIGIT]) return j + 1;
`else
    if (ta == tb_) return NDIG + 1;
`endif
    return NDIG + 1;
  endfunction

  // Result monitor: every done pops one scoreboard entry.
  always @(negedge clk) begin
    if (done) begin
      chk("onehot", int'(eq) + int'(gt) + int'(lt), 1);
      chk("dbl_done", prev_done, 0);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("result", {eq, gt, lt}, exp_q.pop_front());
    end
    prev_done = done;
  end

  task automatic run_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic sm,
                         input int inj_at, input logic start_at_done);
    logic [2:0] er;
    int el, n, bcnt;
    logic got;
    er = model_res(ta, tb_, sm);
    el = model_lat(ta, tb_);
    @(negedge clk);
    a = ta; b = tb_; signed_mode = sm; start = 1'b1;
    exp_q.push_back(er);
    n = 0; bcnt = 0; got = 1'b0;
    while (n <= 20) begin
      @(negedge clk);
      start = 1'b0;
      a = ~ta; b = ~tb_; signed_mode = ~sm;
      if (done) begin got = 1'b1; break; end
      if (busy) bcnt++;
      chk("hold_pre_done", {eq, gt, lt}, last_res);
      if (n == inj_at) begin
        start = 1'b1;
        a = $urandom(); b = $urandom();
      end
      n++;
    end
    chk("done_seen", got, 1);
    chk("latency", n, el);
    chk("busy_cycles", bcnt, el);
    chk("busy_at_done", busy, 0);
    last_res = er;
    if (start_at_done) begin
      start = 1'b1; a = 16'h0000; b = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
      chk("start_at_done_ignored", busy, 0);
    end
    @(negedge clk);
    chk("hold_post_done", {eq, gt, lt}, er);
  endtask

  task automatic abort_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_);
    @(negedge clk);
    a = ta; b = tb_; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_before", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, done, eq, gt, lt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 3'b000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, eq, gt, lt}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outs", {busy, done, eq, gt, lt}, 0);

    run_cmp(16'h0000, 16'h0000, 1'b0, -1, 1'b0);
    run_cmp(16'hA000, 16'h5FFF, 1'b0, -1, 1'b0);
    run_cmp(16'h1234, 16'h1235, 1'b0, -1, 1'b0);
    run_cmp(16'h8000, 16'h0001, 1'b1, -1, 1'b0);
    run_cmp(16'h8000, 16'h0001, 1'b0, -1, 1'b0);
    run_cmp(16'h00F0, 16'h00F1, 1'b0, 1, 1'b0);
    run_cmp(16'hFFFF, 16'hFFFE, 1'b1, -1, 1'b1);
    abort_cmp(16'h1111, 16'h2222);
    run_cmp(16'h7FFF, 16'h8000, 1'b1, -1, 1'b0);
    run_cmp(16'h7FFF, 16'h8000, 1'b0, 0, 1'b0);
    run_cmp(16'h8000, 16'h8000, 1'b1, -1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom());
      rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? (ra ^ 16'($urandom_range(1, 15))) : 16'($urandom()));
      run_cmp(ra, rb, 1'(i % 2), -1, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
